// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction encodings, default timing
// constants and the press-priority helper used by the input conditioner.
package snake_pkg;

    localparam int unsigned DIR_RIGHT = 3;
    localparam int unsigned DIR_LEFT  = 2;
    localparam int unsigned DIR_UP    = 1;
    localparam int unsigned DIR_DOWN  = 0;

    typedef enum logic [1:0] {
        DIR_CODE_RIGHT = 2'b00,
        DIR_CODE_LEFT  = 2'b01,
        DIR_CODE_UP    = 2'b10,
        DIR_CODE_DOWN  = 2'b11
    } dir_code_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEFAULT_TICK_DIV        = 10_000_000;
    localparam int unsigned DEFAULT_CNT_W           = 24;

    // Reduce same-cycle presses to one request; order matches the controller.
    function automatic logic [3:0] newest_press(input logic [3:0] evt);
        logic [3:0] sel;
        sel = '0;
        if (evt[DIR_RIGHT])     sel[DIR_RIGHT] = 1'b1;
        else if (evt[DIR_LEFT]) sel[DIR_LEFT]  = 1'b1;
        else if (evt[DIR_UP])   sel[DIR_UP]    = 1'b1;
        else if (evt[DIR_DOWN]) sel[DIR_DOWN]  = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/snake_input_conditioner_debouncer.sv
// One pushbutton: two-flop synchroniser, hold-time debounce counter and a
// single-cycle pulse on each accepted press (release is silent).
module button_debouncer
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: the counter and stable level sit on the async reset too, so a press
    // in flight at reset is dropped and a held button must re-qualify from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync      <= '0;
            stable    <= 1'b0;
            stable_d  <= 1'b0;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            sync      <= {sync[0], btn};
            stable_d  <= stable;
            press_evt <= stable & ~stable_d;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_input_conditioner.sv
// Front end of the snake controller: debounced direction requests latched per
// game period, plus the divided game clock and its rising-edge tick strobe.
module snake_input_conditioner
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output logic game_clk,
    output logic tick,
    output logic up,
    output logic down,
    output logic left,
    output logic right
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(TICK_DIV / 2);

    logic [3:0]       raw_btn;
    logic [3:0]       press_evt;
    logic [3:0]       pending;
    logic [3:0]       merged;
    logic [3:0]       dir_q;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_next;
    logic             wrap;

    assign raw_btn[DIR_RIGHT] = btn_right;
    assign raw_btn[DIR_LEFT]  = btn_left;
    assign raw_btn[DIR_UP]    = btn_up;
    assign raw_btn[DIR_DOWN]  = btn_down;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debouncer (
            .clk      (clk),
            .rst      (rst),
            .btn      (raw_btn[i]),
            .press_evt(press_evt[i])
        );
    end

    assign wrap     = (div_cnt == DIV_LAST);
    assign div_next = wrap ? '0 : div_cnt + 1'b1;
    // A press arriving this cycle replaces whatever was pending.
    assign merged   = (|press_evt) ? newest_press(press_evt) : pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            game_clk <= 1'b0;
            tick     <= 1'b0;
            pending  <= '0;
            dir_q    <= '0;
        end else begin
            div_cnt  <= div_next;
            game_clk <= (div_next >= DIV_HALF);
            tick     <= (div_next == DIV_HALF);
            // Load on the game_clk falling edge so the level is settled well
            // before the consumer samples it on the next rising edge.
            if (wrap) begin
                dir_q   <= merged;
                pending <= '0;
            end else begin
                pending <= merged;
            end
        end
    end

    assign right = dir_q[DIR_RIGHT];
    assign left  = dir_q[DIR_LEFT];
    assign up    = dir_q[DIR_UP];
    assign down  = dir_q[DIR_DOWN];

endmodule

// File: tb/tb_snake_input_conditioner.sv
// Randomised and directed bench for snake_input_conditioner, checked every cycle
// against a history-based reference model of debounce, arbitration and load.
module tb_snake_input_conditioner;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic btn_up    = 1'b0;
    logic btn_down  = 1'b0;
    logic btn_left  = 1'b0;
    logic btn_right = 1'b0;
    logic game_clk, tick, up, down, left, right;

    int checks = 0;
    int errors = 0;

    snake_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (DIV),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .game_clk (game_clk),
        .tick     (tick),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-edge histories since reset release, edge 1 first.
    int         m_edges = 0;
    logic [3:0] raw_q[$];
    logic [3:0] rose_q[$];
    logic [3:0] evt_q[$];
    logic [3:0] m_stable = '0;
    logic [3:0] m_out    = '0;
    logic       m_gclk   = 1'b0;
    logic       m_tick   = 1'b0;

    function automatic logic [3:0] raw_at(input int k);
        if (k < 1 || k > raw_q.size()) return 4'b0000;
        return raw_q[k-1];
    endfunction

    function automatic logic [3:0] newest_of(input logic [3:0] e);
        logic [3:0] r;
        r = '0;
        for (int b = 3; b >= 0; b--) begin
            if (e[b]) begin
                r[b] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        m_edges  = 0;
        raw_q.delete();
        rose_q.delete();
        evt_q.delete();
        m_stable = '0;
        m_out    = '0;
        m_gclk   = 1'b0;
        m_tick   = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] rose, ev, s;
        bit         all_diff;
        int         n;
        m_edges++;
        n = m_edges;
        raw_q.push_back({btn_right, btn_left, btn_up, btn_down});
        // Synchronised sample at edge n is the raw sample from edge n-2; a
        // level is accepted once the last DEB samples all disagree with it.
        rose = '0;
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                s = raw_at(n - 2 - j);
                if (s[b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_stable[b] = ~m_stable[b];
                rose[b]     = m_stable[b];
            end
        end
        rose_q.push_back(rose);
        ev = (n >= 3) ? rose_q[n-3] : 4'b0000;
        evt_q.push_back(ev);
        m_gclk = (n % DIV) >= DIV / 2;
        m_tick = (n % DIV) == DIV / 2;
        if (n % DIV == 0) begin
            m_out = '0;
            for (int k = n; k >= 1 && k > n - DIV; k--) begin
                if (evt_q[k-1] != 4'b0000) begin
                    m_out = newest_of(evt_q[k-1]);
                    break;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else      model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cycle", 32'({game_clk, tick, right, left, up, down}),
                  32'({m_gclk, m_tick, m_out}));
            check("one_hot", 32'($countones({right, left, up, down}) <= 1), 32'd1);
        end
    end

    task automatic goto_edge(input int n);
        int guard;
        guard = 0;
        while (m_edges < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("reach_edge", 32'(m_edges), 32'(n));
    endtask

    task automatic check_dirs(input string name, input logic [3:0] exp);
        check(name, 32'({right, left, up, down}), 32'(exp));
    endtask

    initial begin
        logic [3:0] rb;

        // Reset, then divider phase
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", 32'({game_clk, tick, right, left, up, down}), 32'd0);
        rst = 1'b1;
        goto_edge(1);
        check("gclk_e1", 32'({game_clk, tick}), 32'b00);
        btn_right = 1'b1;
        goto_edge(3);
        check("gclk_e3", 32'({game_clk, tick}), 32'b00);
        goto_edge(4);
        check("gclk_rise", 32'({game_clk, tick}), 32'b11);
        goto_edge(5);
        check("gclk_high", 32'({game_clk, tick}), 32'b10);
        goto_edge(8);
        check("gclk_fall", 32'({game_clk, tick}), 32'b00);
        goto_edge(12);
        check("tick_2nd", 32'({game_clk, tick}), 32'b11);

        // Clean press on right: event at edge 9, loaded at wrap 16
        goto_edge(15);
        check_dirs("right_before", 4'b0000);
        goto_edge(16);
        check_dirs("right_load", 4'b1000);
        goto_edge(23);
        check_dirs("right_hold", 4'b1000);
        goto_edge(24);
        check_dirs("right_clear", 4'b0000);
        btn_right = 1'b0;

        // Bounce on up for 20 cycles, then a clean hold
        for (int i = 0; i < 20; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            goto_edge(25 + i);
        end
        btn_up = 1'b1;
        goto_edge(55);
        check_dirs("up_before", 4'b0000);
        goto_edge(56);
        check_dirs("up_load", 4'b0010);
        goto_edge(63);
        check_dirs("up_hold", 4'b0010);
        goto_edge(64);
        check_dirs("up_clear", 4'b0000);
        btn_up = 1'b0;

        // Newest wins: left then down one cycle before the wrap
        goto_edge(65);
        btn_left = 1'b1;
        goto_edge(71);
        btn_down = 1'b1;
        goto_edge(80);
        check_dirs("newest_down", 4'b0001);
        btn_left = 1'b0;
        btn_down = 1'b0;

        // Simultaneous left and right
        goto_edge(89);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        goto_edge(104);
        check_dirs("simul_right", 4'b1000);
        btn_left  = 1'b0;
        btn_right = 1'b0;

        // Event coincident with the wrap goes straight to the outputs
        goto_edge(112);
        btn_up = 1'b1;
        goto_edge(119);
        check_dirs("wrap_before", 4'b0000);
        goto_edge(120);
        check_dirs("wrap_load", 4'b0010);
        goto_edge(121);
        btn_up = 1'b0;
        goto_edge(128);
        check_dirs("wrap_next", 4'b0000);

        // Reset with up pending and div_cnt = 5, button held through it
        goto_edge(131);
        btn_up = 1'b1;
        goto_edge(141);
        check("pre_reset_gclk", 32'(game_clk), 32'd1);
        rst = 1'b0;
        #1;
        check("reset_async", 32'({game_clk, tick, right, left, up, down}), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        goto_edge(7);
        check_dirs("held_before", 4'b0000);
        goto_edge(8);
        check_dirs("held_load", 4'b0010);
        goto_edge(16);
        check_dirs("held_clear", 4'b0000);
        btn_up = 1'b0;

        // Random button activity with runs both shorter and longer than DEB
        rb = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            #1;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rb[b] = ~rb[b];
            end
            {btn_right, btn_left, btn_up, btn_down} = rb;
        end
        {btn_right, btn_left, btn_up, btn_down} = 4'b0000;
        repeat (30) @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_input_conditioner.md
Name: snake_input_conditioner

Overview:
- Upstream stage of the snake game's movement/render controller.
- Synchronises and debounces the four raw direction buttons and latches the newest press as a one-hot request.
- Generates the slow game clock that the controller uses as its movement clock, plus a single-cycle tick strobe in the fast domain.
- Presents up/down/left/right as levels that are stable across every game_clk rising edge, so a short press between ticks is never lost.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised button level must hold before it is accepted (10 ms at 100 MHz)
TICK_DIV, 10_000_000, clk cycles per game_clk period (must be even and at least 4)
CNT_W, 24, width of the debounce and divider counters (must hold max(DEBOUNCE_CYCLES, TICK_DIV)-1)

Ports:
clk  in  1  system clock (100 MHz); sole clock
rst  in  1  asynchronous reset, active-low (0 = reset asserted), released synchronously to clk externally
btn_up  in  1  raw pushbutton, asynchronous, bouncy
btn_down  in  1  raw pushbutton
btn_left  in  1  raw pushbutton
btn_right  in  1  raw pushbutton
game_clk  out  1  registered 50% duty divided clock feeding the controller's clk
tick  out  1  one-cycle strobe, asserted in the clk cycle where game_clk goes 0 to 1
up  out  1  direction request, registered
down  out  1  direction request, registered
left  out  1  direction request, registered
right  out  1  direction request, registered

Behaviour:
- Reset (rst=0, async): all sync flops, stable levels, debounce counters, pending, div_cnt, game_clk, tick, up, down, left and right go to 0. A reset mid-press is discarded. After release, a held button counts as a new press only once it has been debounced from 0.
- Synchroniser: a 2-flop chain per button.
- Debounce, per button:
  - If sync != stable, cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1, stable <= sync and cnt <= 0.
  - If sync == stable, cnt <= 0, so any bounce restarts the count.
  - press_evt is a 1-cycle pulse on a 0-to-1 transition of stable. Release generates no event.
  - Latency: a raw edge held clean produces press_evt DEBOUNCE_CYCLES+3 clk cycles later.
- Press arbitration:
  - pending is a 4-bit one-hot (or zero) register.
  - Any press_evt overwrites pending, so the newest press wins.
  - Simultaneous events in the same cycle resolve as right > left > up > down, which matches the consumer's priority.
  - Holding a button does not re-trigger.
- Divider:
  - div_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - game_clk <= (next div_cnt >= TICK_DIV/2), so game_clk is registered and glitch-free.
  - tick = 1 exactly in the cycle where game_clk transitions 0 to 1 (div_cnt reaches TICK_DIV/2).
- Output load:
  - In the cycle where div_cnt wraps to 0 (game_clk falling), {right,left,up,down} <= pending-with-this-cycle's-events and pending <= 0.
  - An event arriving in the load cycle goes straight to the outputs and is not retained in pending.
  - Outputs are constant for the whole period, including the game_clk rising edge, so the consumer samples a stable value.
  - A request is visible for exactly one game_clk period, then clears unless a new press arrives.
- Outputs are at most one-hot at all times.
- The reversal rule (e.g. left while moving right) is not filtered here; it belongs to the consumer.

Decomposition:
- Shared package snake_pkg holds:
  - direction one-hot bit indices DIR_RIGHT=3, DIR_LEFT=2, DIR_UP=1, DIR_DOWN=0
  - the 2-bit direction codes (00 right, 01 left, 10 up, 11 down) used by the controller
  - default DEBOUNCE_CYCLES and TICK_DIV constants
- One sub-module, button_debouncer (synchroniser + counter + rising-edge pulse, parameterised by DEBOUNCE_CYCLES and CNT_W), instantiated four times.
- Arbitration, divider and output registers stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=8):
- Reset and divider: hold rst=0 for 3 cycles, then release → all outputs 0 during reset. game_clk is 0 for 4 cycles and 1 for 4 cycles, repeating. tick pulses once per 8 cycles, coincident with each game_clk rise.
- Clean press: btn_right 0 to 1 held at div_cnt=1 → press_evt 7 cycles later. right=1 loads at the next div_cnt wrap, holds for 8 cycles, then returns to 0 while the button is still held.
- Bounce rejection: btn_up toggles every 2 cycles for 20 cycles, then holds 1 → no event during the toggling. Exactly one up request follows, debounced from the final stable edge.
- Newest wins: a left event lands, then a down event lands 1 cycle before the wrap → outputs load down=1 with left=0. Simultaneous left and right events → right=1 only.
- Load-cycle boundary: an event coincident with the div_cnt wrap → output asserted at that load and pending=0 afterward. The following period's outputs are all 0.
- Reset mid-operation: assert rst=0 while pending=up and div_cnt=5 → all outputs and game_clk return to 0 immediately. A button held through reset yields one request after release plus debounce.
